// File: rtl/ether_pkg.sv
// Shared RMII definitions: transmit-side FSM states, preamble dibits and defaults.
package ether_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_PREAM = 2'd1,
    TX_DATA  = 2'd2,
    TX_IFG   = 2'd3
  } tx_state_e;

  localparam logic [1:0] PREAM_EXPECT = 2'b01;
  localparam logic [1:0] PREAM_LAST   = 2'b11;

  localparam int PREAM_DIBITS_DEF = 32;
  localparam int IFG_CYCLES_DEF   = 48;

  // Dibit for preamble position idx of a len-dibit preamble; the SFD closes it.
  function automatic logic [1:0] pream_dibit(input int unsigned idx, input int unsigned len);
    return (idx == len - 1) ? PREAM_LAST : PREAM_EXPECT;
  endfunction

endpackage

// File: rtl/ether_tx_serializer.sv
// Byte load/shift register emitting dibits LSB-first; byte_done marks the 4th dibit.
module ether_tx_serializer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  input  logic       shift,
  output logic [1:0] dibit,
  output logic [1:0] dibit_nxt,
  output logic       byte_done
);

  logic [7:0] sh_q, sh_d;
  logic [1:0] idx_q, idx_d;

  always_comb begin
    sh_d  = sh_q;
    idx_d = idx_q;
    if (load) begin
      sh_d  = din;
      idx_d = 2'd0;
    end else if (shift) begin
      sh_d  = {2'b00, sh_q[7:2]};
      idx_d = idx_q + 2'd1;
    end
  end

  assign dibit     = sh_q[1:0];
  assign dibit_nxt = sh_q[3:2];
  assign byte_done = (idx_q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q  <= '0;
      idx_q <= '0;
    end else begin
      sh_q  <= sh_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/ether_tx_arbiter.sv
// Round-robin frame arbiter for two byte requesters onto the RMII transmit pins.
module ether_tx_arbiter
  import ether_pkg::*;
#(
  parameter int PREAM_DIBITS = PREAM_DIBITS_DEF,
  parameter int IFG_CYCLES   = IFG_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv_a,
  input  logic [7:0] axiid_a,
  input  logic       axiil_a,
  output logic       axiir_a,
  input  logic       axiiv_b,
  input  logic [7:0] axiid_b,
  input  logic       axiil_b,
  output logic       axiir_b,
  output logic       txen,
  output logic [1:0] txd,
  output logic [1:0] grant,
  output logic       underrun
);

  localparam int CW = 16;

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    grant_q, grant_d;
  logic          rr_b_q, rr_b_d;   // 1 when B was granted last
  logic          last_q, last_d;
  logic          txen_q, txen_d;
  logic [1:0]    txd_q, txd_d;
  logic          underrun_q, underrun_d;

  logic       req_any, win_b, sel_b, sel_v, sel_l, rdy;
  logic [7:0] sel_d;
  logic       ld, sh, byte_done;
  logic [1:0] dibit, dibit_nxt;

  assign req_any = axiiv_a | axiiv_b;
  assign win_b   = axiiv_b & (~axiiv_a | ~rr_b_q);
  assign sel_b   = (state_q == TX_IDLE) ? win_b : grant_q[1];
  assign sel_v   = sel_b ? axiiv_b : axiiv_a;
  assign sel_d   = sel_b ? axiid_b : axiid_a;
  assign sel_l   = sel_b ? axiil_b : axiil_a;

  assign rdy     = ((state_q == TX_IDLE) && req_any) ||
                   ((state_q == TX_DATA) && byte_done && !last_q);
  assign axiir_a = rdy & ~sel_b;
  assign axiir_b = rdy & sel_b;

  ether_tx_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .din       (sel_d),
    .shift     (sh),
    .dibit     (dibit),
    .dibit_nxt (dibit_nxt),
    .byte_done (byte_done)
  );

  // txd/txen are registered, so each state computes what the pins show next cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    rr_b_d     = rr_b_q;
    last_d     = last_q;
    txen_d     = 1'b0;
    txd_d      = 2'b00;
    underrun_d = 1'b0;
    ld         = 1'b0;
    sh         = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (req_any) begin
          ld      = 1'b1;
          last_d  = sel_l;
          grant_d = win_b ? 2'b10 : 2'b01;
          rr_b_d  = win_b;
          state_d = TX_PREAM;
          cnt_d   = '0;
          txen_d  = 1'b1;
          txd_d   = pream_dibit(32'd0, PREAM_DIBITS);
        end
      end
      TX_PREAM: begin
        txen_d = 1'b1;
        if (cnt_q == CW'(PREAM_DIBITS - 1)) begin
          state_d = TX_DATA;
          txd_d   = dibit;
        end else begin
          cnt_d = cnt_q + 1'b1;
          txd_d = pream_dibit(32'(cnt_q) + 32'd1, PREAM_DIBITS);
        end
      end
      TX_DATA: begin
        if (!byte_done) begin
          sh     = 1'b1;
          txen_d = 1'b1;
          txd_d  = dibit_nxt;
        end else if (!last_q && sel_v) begin
          ld     = 1'b1;
          last_d = sel_l;
          txen_d = 1'b1;
          txd_d  = sel_d[1:0];
        end else begin
          // Either the last byte finished or the requester ran dry mid-frame.
          state_d    = TX_IFG;
          cnt_d      = '0;
          grant_d    = 2'b00;
          underrun_d = ~last_q;
        end
      end
      TX_IFG: begin
        if (cnt_q == CW'(IFG_CYCLES - 1)) state_d = TX_IDLE;
        else                              cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TX_IDLE;
      cnt_q      <= '0;
      grant_q    <= 2'b00;
      rr_b_q     <= 1'b0;
      last_q     <= 1'b0;
      txen_q     <= 1'b0;
      txd_q      <= 2'b00;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      rr_b_q     <= rr_b_d;
      last_q     <= last_d;
      txen_q     <= txen_d;
      txd_q      <= txd_d;
      underrun_q <= underrun_d;
    end
  end

  assign txen     = txen_q;
  assign txd      = txd_q;
  assign grant    = grant_q;
  assign underrun = underrun_q;

endmodule

// File: tb/tb_ether_tx_arbiter.sv
// Directed bench for ether_tx_arbiter: records each txen burst and checks it by assertion.
module tb_ether_tx_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       axiiv_a = 1'b0, axiil_a = 1'b0, axiiv_b = 1'b0, axiil_b = 1'b0;
  logic [7:0] axiid_a = 8'h00, axiid_b = 8'h00;
  logic       axiir_a, axiir_b, txen, underrun;
  logic [1:0] txd, grant;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs_cyc = 0;

  // per-frame records from the negedge monitor
  int         nf = 0;
  int         low_cnt = 0;
  bit         in_frame = 1'b0;
  bit         prev_txen = 1'b0;
  int         flen  [32];
  int         fgap  [32];
  int         frise [32];
  logic [1:0] fgrant[32];
  logic [1:0] fdib  [32][64];
  int gchg = 0, xrdy = 0, idle_txd = 0, urun_cyc = 0, urun_good = 0;

  logic [1:0] exp1 [12] = '{2'b01, 2'b01, 2'b01, 2'b01,  2'b01, 2'b01, 2'b01, 2'b11,
                            2'b11, 2'b11, 2'b00, 2'b00};
  logic [1:0] exp_3c [4] = '{2'b00, 2'b11, 2'b11, 2'b00};
  logic [1:0] exp_5a [4] = '{2'b10, 2'b10, 2'b01, 2'b01};
  logic [1:0] exp_a5 [4] = '{2'b01, 2'b01, 2'b10, 2'b10};

  ether_tx_arbiter dut (
    .clk(clk), .rst(rst),
    .axiiv_a(axiiv_a), .axiid_a(axiid_a), .axiil_a(axiil_a), .axiir_a(axiir_a),
    .axiiv_b(axiiv_b), .axiid_b(axiid_b), .axiil_b(axiil_b), .axiir_b(axiir_b),
    .txen(txen), .txd(txd), .grant(grant), .underrun(underrun)
  );

  initial forever #10 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    @(negedge clk);
    if (txen === 1'b1) begin
      if (!in_frame) begin
        in_frame = 1'b1; fgap[nf] = low_cnt; frise[nf] = cyc; flen[nf] = 0; fgrant[nf] = grant;
      end
      if (flen[nf] < 64) fdib[nf][flen[nf]] = txd;
      flen[nf]++;
      if (grant !== fgrant[nf]) gchg++;
      low_cnt = 0;
    end else begin
      if (in_frame) begin in_frame = 1'b0; if (nf < 31) nf++; end
      low_cnt++;
      if (txd !== 2'b00) idle_txd++;
    end
    if (underrun === 1'b1) begin
      urun_cyc++;
      if (txen === 1'b0 && prev_txen) urun_good++;
    end
    if ((grant == 2'b01 && axiir_b) || (grant == 2'b10 && axiir_a)) xrdy++;
    prev_txen = (txen === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit sb, input logic [7:0] d, input bit l, input bit first,
                      output bit ok);
    ok = 1'b0;
    if (sb) begin axiiv_b = 1'b1; axiid_b = d; axiil_b = l; end
    else    begin axiiv_a = 1'b1; axiid_a = d; axiil_a = l; end
    for (int t = 0; t < 600 && !ok; t++) begin
      @(negedge clk);
      if (sb ? axiir_b : axiir_a) begin
        if (first) hs_cyc = cyc;
        ok = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input bit sb, input logic [7:0] b0, input logic [7:0] b1,
                      input logic [7:0] b2, input int n);
    bit ok;
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      push(sb, d, i == n - 1, i == 0, ok);
      chk("handshake", 32'(ok), 32'd1);
    end
    if (sb) begin axiiv_b = 1'b0; axiil_b = 1'b0; end
    else    begin axiiv_a = 1'b0; axiil_a = 1'b0; end
  endtask

  task automatic wait_done(input int k, input int budget);
    int t = 0;
    while (!(nf >= k && low_cnt >= 2) && t < budget) begin @(negedge clk); t++; end
    chk("frame_complete_in_time", 32'(nf >= k), 32'd1);
  endtask

  task automatic chk_pream(input string tag, input int f);
    int miss = 0;
    for (int i = 0; i < 31; i++) if (fdib[f][i] !== 2'b01) miss++;
    chk({tag, "_pream01"}, 32'(miss), 32'd0);
    chk({tag, "_sfd"}, 32'(fdib[f][31]), 32'(2'b11));
  endtask

  initial begin
    int  base;
    bit  ok;

    // reset state
    #5;
    chk("rst_txen", 32'(txen), 32'd0);
    chk("rst_txd", 32'(txd), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_ready", 32'({axiir_a, axiir_b}), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // single 3-byte frame from A
    base = nf;
    send(1'b0, 8'h55, 8'hD5, 8'h0F, 3);
    wait_done(base + 1, 300);
    chk("a_len", 32'(flen[base]), 32'd44);
    chk("a_grant", 32'(fgrant[base]), 32'(2'b01));
    chk("a_latency", 32'(frise[base]), 32'(hs_cyc + 1));
    chk_pream("a", base);
    for (int i = 0; i < 12; i++) chk("a_data", 32'(fdib[base][32 + i]), 32'(exp1[i]));
    chk("a_no_underrun", 32'(urun_cyc), 32'd0);

    // simultaneous requests, three frames each
    base = nf;
    fork
      for (int i = 0; i < 3; i++) send(1'b0, 8'hA0, 8'hA1, 8'h00, 2);
      for (int i = 0; i < 3; i++) send(1'b1, 8'hB0, 8'hB1, 8'h00, 2);
    join
    wait_done(base + 6, 400);
    for (int i = 0; i < 6; i++)
      chk("rr_grant", 32'(fgrant[base + i]), (i % 2 == 0) ? 32'(2'b10) : 32'(2'b01));
    for (int i = 1; i < 6; i++) chk("rr_gap", 32'(fgap[base + i]), 32'd49);
    chk("rr_len", 32'(flen[base + 5]), 32'd40);
    chk("loser_ready", 32'(xrdy), 32'd0);

    // underrun after the first byte of a would-be 4-byte frame
    base = nf;
    push(1'b0, 8'h3C, 1'b0, 1'b1, ok);
    chk("ur_handshake", 32'(ok), 32'd1);
    axiiv_a = 1'b0;
    wait_done(base + 1, 200);
    send(1'b0, 8'h81, 8'h00, 8'h00, 1);
    wait_done(base + 2, 300);
    chk("ur_len", 32'(flen[base]), 32'd36);
    for (int i = 0; i < 4; i++) chk("ur_data", 32'(fdib[base][32 + i]), 32'(exp_3c[i]));
    chk("ur_pulse_cycles", 32'(urun_cyc), 32'd1);
    chk("ur_pulse_at_fall", 32'(urun_good), 32'd1);
    chk("ur_next_gap", 32'(fgap[base + 1]), 32'd49);
    chk("ur_next_grant", 32'(fgrant[base + 1]), 32'(2'b01));

    // reset in the middle of DATA
    base = nf;
    push(1'b1, 8'h11, 1'b0, 1'b1, ok);
    chk("mr_handshake", 32'(ok), 32'd1);
    axiid_b = 8'h22;
    repeat (34) @(posedge clk);
    #3;
    chk("mr_txen_before", 32'(txen), 32'd1);
    rst = 1'b1;
    axiiv_b = 1'b0;
    #1;
    chk("mr_txen_async", 32'(txen), 32'd0);
    chk("mr_grant_async", 32'(grant), 32'd0);
    chk("mr_txd_async", 32'(txd), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send(1'b1, 8'h5A, 8'h00, 8'h00, 1);
    wait_done(base + 2, 300);
    chk("mr_len", 32'(flen[base + 1]), 32'd36);
    chk("mr_grant", 32'(fgrant[base + 1]), 32'(2'b10));
    chk("mr_latency", 32'(frise[base + 1]), 32'(hs_cyc + 1));
    chk_pream("mr", base + 1);
    for (int i = 0; i < 4; i++) chk("mr_data", 32'(fdib[base + 1][32 + i]), 32'(exp_5a[i]));

    // single-byte frame from B, then another B request straight away
    base = nf;
    send(1'b1, 8'hA5, 8'h00, 8'h00, 1);
    send(1'b1, 8'h0F, 8'h00, 8'h00, 1);
    wait_done(base + 2, 300);
    chk("sb_len", 32'(flen[base]), 32'd36);
    for (int i = 0; i < 4; i++) chk("sb_data", 32'(fdib[base][32 + i]), 32'(exp_a5[i]));
    chk("sb_gap", 32'(fgap[base + 1]), 32'd49);
    chk("sb_grant0", 32'(fgrant[base]), 32'(2'b10));
    chk("sb_grant1", 32'(fgrant[base + 1]), 32'(2'b10));
    chk("sb_len1", 32'(flen[base + 1]), 32'd36);

    // whole-run invariants
    chk("grant_stable_in_frame", 32'(gchg), 32'd0);
    chk("txd_zero_when_idle", 32'(idle_txd), 32'd0);
    chk("underrun_total", 32'(urun_cyc), 32'd1);
    chk("loser_ready_total", 32'(xrdy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
